// File: rtl/mem_pkg.sv
// Definitions shared by the memory manager FSM and the SDRAM user master:
// FSM state encoding, block size and the HPS/Atom shared-window memory map.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    WR_REQ  = 2'd3
  } state_t;

  // One mining block is 96 bytes, i.e. 24 32-bit words.
  localparam int MAX_WORDS = 24;

  // Shared SDRAM window map (byte addresses).
  localparam logic [27:0] ATOM_REG    = 28'h8000000;
  localparam logic [27:0] HDWR_REG    = 28'h8000004;
  localparam logic [27:0] MINE_BLOCK  = 28'h8000008;
  localparam logic [27:0] NONCE_BLOCK = 28'h8000068;

  // Value the Atom side writes into ATOM_REG to signal a handshake.
  localparam logic [31:0] HANDSHAKE = 32'hAAAA0000;

endpackage

// File: rtl/ram_user_master.sv
// SDRAM user master: turns a read/write command of up to one block into a
// sequence of single-word Avalon-MM transfers, one transfer in flight at a time.
// Read words come back as a one-cycle-valid stream; writes end with a done pulse.
module ram_user_master #(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 24,
  parameter int LEN_W     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rdwr,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [LEN_W-1:0]  cmd_words,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_data_ack,
  output logic              read_user_data_available,
  output logic [DATA_W-1:0] read_user_buffer_output_data,
  output logic              write_control_done,
  output logic              busy,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest
);

  import mem_pkg::*;

  localparam logic [LEN_W-1:0]  MAX_CNT   = LEN_W'(MAX_WORDS);
  localparam logic [LEN_W-1:0]  ONE_WORD  = LEN_W'(1);
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                done_q, done_d;
  logic [LEN_W-1:0]    words_sat;
  logic                accept;

  // Oversized requests are clamped to one block rather than rejected.
  assign words_sat = (cmd_words > MAX_CNT) ? MAX_CNT : cmd_words;
  assign accept    = (state_q == IDLE) && !reset && cmd_valid;

  // Next-state, bus strobes and per-word bookkeeping.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    done_d      = 1'b0;
    cmd_ready   = 1'b0;
    avm_read    = 1'b0;
    avm_write   = 1'b0;
    wr_data_ack = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = !reset;
        if (accept) begin
          addr_d  = {cmd_address[ADDR_W-1:2], 2'b00};
          count_d = words_sat;
          if (words_sat == '0) begin
            done_d = cmd_rdwr;
          end else begin
            state_d = cmd_rdwr ? WR_REQ : RD_REQ;
          end
        end
      end

      RD_REQ: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) begin
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (avm_readdatavalid) begin
          rdata_d  = avm_readdata;
          rvalid_d = 1'b1;
          addr_d   = addr_q + WORD_STEP;
          count_d  = count_q - ONE_WORD;
          state_d  = (count_q == ONE_WORD) ? IDLE : RD_REQ;
        end
      end

      WR_REQ: begin
        avm_write   = 1'b1;
        wr_data_ack = !avm_waitrequest;
        if (!avm_waitrequest) begin
          addr_d  = addr_q + WORD_STEP;
          count_d = count_q - ONE_WORD;
          if (count_q == ONE_WORD) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any command in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
    end
  end

  assign avm_address                  = addr_q;
  assign avm_writedata                = wr_data;
  assign read_user_data_available     = rvalid_q;
  assign read_user_buffer_output_data = rdata_q;
  assign write_control_done           = done_q;
  assign busy                         = (state_q != IDLE);

endmodule

// File: tb/tb_ram_user_master.sv
// Directed bench for ram_user_master. Inputs change just after the falling
// edge; outputs are sampled at the falling edge (or #1 later for paths that
// depend combinationally on inputs driven in the same cycle).
module tb_ram_user_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rdwr;
  logic [27:0] cmd_address;
  logic [4:0]  cmd_words;
  logic [31:0] wr_data;
  logic        wr_data_ack;
  logic        read_user_data_available;
  logic [31:0] read_user_buffer_output_data;
  logic        write_control_done;
  logic        busy;
  logic [27:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        avm_waitrequest;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  ram_user_master dut (
    .clk                          (clk),
    .reset                        (reset),
    .cmd_valid                    (cmd_valid),
    .cmd_ready                    (cmd_ready),
    .cmd_rdwr                     (cmd_rdwr),
    .cmd_address                  (cmd_address),
    .cmd_words                    (cmd_words),
    .wr_data                      (wr_data),
    .wr_data_ack                  (wr_data_ack),
    .read_user_data_available     (read_user_data_available),
    .read_user_buffer_output_data (read_user_buffer_output_data),
    .write_control_done           (write_control_done),
    .busy                         (busy),
    .avm_address                  (avm_address),
    .avm_read                     (avm_read),
    .avm_write                    (avm_write),
    .avm_writedata                (avm_writedata),
    .avm_readdata                 (avm_readdata),
    .avm_readdatavalid            (avm_readdatavalid),
    .avm_waitrequest              (avm_waitrequest)
  );

  // Present a command for one cycle; returns at the falling edge after acceptance.
  task automatic issueCmd(input logic rdwr, input logic [27:0] addr, input logic [4:0] words);
    cmd_valid   = 1'b1;
    cmd_rdwr    = rdwr;
    cmd_address = addr;
    cmd_words   = words;
    @(negedge clk);
    cmd_valid   = 1'b0;
  endtask

  // Plays the slave side of one read word and reports what was observed.
  task automatic serveRead(input int stalls, input int latency, input logic [31:0] data,
                           output logic [27:0] addrSeen, output int strobes, output int waited,
                           output logic gotPulse, output logic [31:0] gotData, output logic timedOut);
    addrSeen = '0; strobes = 0; waited = 0; gotPulse = 1'b0; gotData = '0; timedOut = 1'b0;
    while (avm_read !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (avm_read !== 1'b1) begin
      timedOut = 1'b1;
      return;
    end
    addrSeen = avm_address;
    strobes  = 1;
    avm_waitrequest = (stalls > 0);
    for (int i = 0; i < stalls; i++) begin
      @(negedge clk);
      if (avm_read === 1'b1) strobes++;
      avm_waitrequest = (i + 1 < stalls);
    end
    for (int i = 0; i < latency - 1; i++) begin
      @(negedge clk);
      if (avm_read === 1'b1) strobes++;
    end
    @(negedge clk);
    if (avm_read === 1'b1) strobes++;
    avm_readdatavalid = 1'b1;
    avm_readdata      = data;
    @(negedge clk);
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    gotPulse = read_user_data_available;
    gotData  = read_user_buffer_output_data;
  endtask

  // Plays the slave side of one write word; returns the cycle after the ack.
  task automatic serveWrite(input int stalls, output logic [27:0] addrSeen, output logic [31:0] dataSeen,
                            output int strobes, output int acks, output logic doneEarly, output logic timedOut);
    int waited;
    addrSeen = '0; dataSeen = '0; strobes = 0; acks = 0; doneEarly = 1'b0; timedOut = 1'b0; waited = 0;
    while (avm_write !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (avm_write !== 1'b1) begin
      timedOut = 1'b1;
      return;
    end
    addrSeen = avm_address;
    for (int i = 0; i <= stalls; i++) begin
      avm_waitrequest = (i < stalls);
      #1;
      if (avm_write === 1'b1) strobes++;
      if (wr_data_ack === 1'b1) begin
        acks++;
        dataSeen = avm_writedata;
      end
      if (write_control_done === 1'b1) doneEarly = 1'b1;
      if (i < stalls) @(negedge clk);
    end
    @(negedge clk);
    avm_waitrequest = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; cmd_valid = 1'b0; cmd_rdwr = 1'b0; cmd_address = '0; cmd_words = '0;
    wr_data = '0; avm_readdata = '0; avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    nChecks++;
    if (cmd_ready !== 1'b0) begin nFails++; $display("[TB] FAIL reset_cmd_ready actual=%b required=0", cmd_ready); end
    nChecks++;
    if ({busy, avm_read, avm_write, read_user_data_available, write_control_done} !== 5'b0) begin
      nFails++;
      $display("[TB] FAIL reset_strobes actual=%b required=00000",
               {busy, avm_read, avm_write, read_user_data_available, write_control_done});
    end
    nChecks++;
    if (avm_address !== 28'h0 || read_user_buffer_output_data !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL reset_regs addr=%h data=%h required=0/0", avm_address, read_user_buffer_output_data);
    end
    reset = 1'b0;
    #1;
    nChecks++;
    if (cmd_ready !== 1'b1) begin nFails++; $display("[TB] FAIL post_reset_cmd_ready actual=%b required=1", cmd_ready); end
  endtask

  task automatic test_single_read;
    logic [27:0] a; int s; int w; logic p; logic [31:0] d; logic to;
    issueCmd(1'b0, mem_pkg::ATOM_REG, 5'd1);
    nChecks++;
    if (busy !== 1'b1) begin nFails++; $display("[TB] FAIL rd1_busy actual=%b required=1", busy); end
    serveRead(0, 2, 32'hAAAA0000, a, s, w, p, d, to);
    nChecks++;
    if (to) begin nFails++; $display("[TB] FAIL rd1_timeout actual=no_read required=read"); end
    nChecks++;
    if (w != 0) begin nFails++; $display("[TB] FAIL rd1_start_cycle actual=%0d required=0", w); end
    nChecks++;
    if (a !== 28'h8000000) begin nFails++; $display("[TB] FAIL rd1_addr actual=%h required=8000000", a); end
    nChecks++;
    if (s != 1) begin nFails++; $display("[TB] FAIL rd1_strobes actual=%0d required=1", s); end
    nChecks++;
    if (p !== 1'b1 || d !== 32'hAAAA0000) begin
      nFails++; $display("[TB] FAIL rd1_data pulse=%b data=%h required=1/aaaa0000", p, d);
    end
    nChecks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      nFails++; $display("[TB] FAIL rd1_ready ready=%b busy=%b required=1/0", cmd_ready, busy);
    end
    @(negedge clk);
    nChecks++;
    if (read_user_data_available !== 1'b0) begin nFails++; $display("[TB] FAIL rd1_pulse_width actual=%b required=0", read_user_data_available); end
  endtask

  task automatic test_burst_read;
    logic [27:0] a; int s; int w; logic p; logic [31:0] d; logic to;
    issueCmd(1'b0, mem_pkg::MINE_BLOCK, 5'd24);
    for (int i = 0; i < 24; i++) begin
      serveRead(int'($urandom_range(0, 2)), int'($urandom_range(1, 3)), 32'hC0DE0000 + i, a, s, w, p, d, to);
      nChecks++;
      if (to || a !== 28'h8000008 + 28'(4 * i)) begin
        nFails++; $display("[TB] FAIL burst_addr[%0d] actual=%h timeout=%b required=%h", i, a, to, 28'h8000008 + 28'(4 * i));
      end
      nChecks++;
      if (p !== 1'b1 || d !== 32'hC0DE0000 + i) begin
        nFails++; $display("[TB] FAIL burst_data[%0d] pulse=%b data=%h required=1/%h", i, p, d, 32'hC0DE0000 + i);
      end
    end
    nChecks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      nFails++; $display("[TB] FAIL burst_end busy=%b ready=%b required=0/1", busy, cmd_ready);
    end
    @(negedge clk);
    nChecks++;
    if (read_user_data_available !== 1'b0 || avm_read !== 1'b0) begin
      nFails++; $display("[TB] FAIL burst_extra pulse=%b read=%b required=0/0", read_user_data_available, avm_read);
    end
  endtask

  task automatic test_single_write;
    logic [27:0] a; logic [31:0] d; int s; int k; logic e; logic to;
    wr_data = 32'hDEADBEEF;
    issueCmd(1'b1, mem_pkg::HDWR_REG, 5'd1);
    serveWrite(3, a, d, s, k, e, to);
    nChecks++;
    if (to || a !== 28'h8000004 || d !== 32'hDEADBEEF) begin
      nFails++; $display("[TB] FAIL wr1_bus addr=%h data=%h timeout=%b required=8000004/deadbeef/0", a, d, to);
    end
    nChecks++;
    if (s != 4 || k != 1) begin nFails++; $display("[TB] FAIL wr1_strobes write=%0d ack=%0d required=4/1", s, k); end
    nChecks++;
    if (e !== 1'b0 || write_control_done !== 1'b1) begin
      nFails++; $display("[TB] FAIL wr1_done early=%b done=%b required=0/1", e, write_control_done);
    end
    nChecks++;
    if (cmd_ready !== 1'b1 || avm_write !== 1'b0) begin
      nFails++; $display("[TB] FAIL wr1_ready ready=%b write=%b required=1/0", cmd_ready, avm_write);
    end
    @(negedge clk);
    nChecks++;
    if (write_control_done !== 1'b0) begin nFails++; $display("[TB] FAIL wr1_done_width actual=%b required=0", write_control_done); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] words [3];
    words[0] = 32'h11111111; words[1] = 32'h22222222; words[2] = 32'h33333333;
    wr_data = words[0];
    issueCmd(1'b1, mem_pkg::NONCE_BLOCK, 5'd3);
    for (int i = 0; i < 3; i++) begin
      wr_data = words[i];
      #1;
      nChecks++;
      if (avm_write !== 1'b1 || wr_data_ack !== 1'b1 || avm_address !== 28'h8000068 + 28'(4 * i) ||
          avm_writedata !== words[i]) begin
        nFails++;
        $display("[TB] FAIL b2b_word[%0d] write=%b ack=%b addr=%h data=%h required=1/1/%h/%h",
                 i, avm_write, wr_data_ack, avm_address, avm_writedata, 28'h8000068 + 28'(4 * i), words[i]);
      end
      @(negedge clk);
    end
    nChecks++;
    if (write_control_done !== 1'b1 || cmd_ready !== 1'b1 || avm_write !== 1'b0) begin
      nFails++; $display("[TB] FAIL b2b_done done=%b ready=%b write=%b required=1/1/0",
                         write_control_done, cmd_ready, avm_write);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_and_clamp;
    logic [27:0] a; int s; int w; logic p; logic [31:0] d; logic to; int extra;
    issueCmd(1'b1, mem_pkg::HDWR_REG, 5'd0);
    nChecks++;
    if (write_control_done !== 1'b1 || busy !== 1'b0 || avm_write !== 1'b0) begin
      nFails++; $display("[TB] FAIL zero_write done=%b busy=%b write=%b required=1/0/0", write_control_done, busy, avm_write);
    end
    issueCmd(1'b0, mem_pkg::ATOM_REG, 5'd0);
    nChecks++;
    if (busy !== 1'b0 || avm_read !== 1'b0 || write_control_done !== 1'b0) begin
      nFails++; $display("[TB] FAIL zero_read busy=%b read=%b done=%b required=0/0/0", busy, avm_read, write_control_done);
    end
    @(negedge clk);
    nChecks++;
    if (read_user_data_available !== 1'b0) begin nFails++; $display("[TB] FAIL zero_read_pulse actual=%b required=0", read_user_data_available); end
    issueCmd(1'b0, 28'h0000100, 5'd31);
    for (int i = 0; i < 24; i++) begin
      serveRead(0, 1, 32'h5A000000 + i, a, s, w, p, d, to);
      nChecks++;
      if (to || a !== 28'h0000100 + 28'(4 * i) || p !== 1'b1 || d !== 32'h5A000000 + i) begin
        nFails++; $display("[TB] FAIL clamp_word[%0d] addr=%h pulse=%b data=%h timeout=%b", i, a, p, d, to);
      end
    end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      if (avm_read === 1'b1 || busy === 1'b1) extra++;
      @(negedge clk);
    end
    nChecks++;
    if (extra != 0) begin nFails++; $display("[TB] FAIL clamp_count extra_cycles=%0d required=0", extra); end
  endtask

  task automatic test_wrap;
    logic [27:0] a; int s; int w; logic p; logic [31:0] d; logic to;
    issueCmd(1'b0, 28'hFFFFFFE, 5'd2);
    serveRead(1, 1, 32'h0000F00D, a, s, w, p, d, to);
    nChecks++;
    if (to || a !== 28'hFFFFFFC || s != 2 || p !== 1'b1 || d !== 32'h0000F00D) begin
      nFails++; $display("[TB] FAIL wrap_first addr=%h strobes=%0d pulse=%b data=%h required=ffffffc/2/1/0000f00d", a, s, p, d);
    end
    serveRead(0, 3, 32'h0000BEEF, a, s, w, p, d, to);
    nChecks++;
    if (to || a !== 28'h0000000 || p !== 1'b1 || d !== 32'h0000BEEF) begin
      nFails++; $display("[TB] FAIL wrap_second addr=%h pulse=%b data=%h required=0000000/1/0000beef", a, p, d);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    issueCmd(1'b0, mem_pkg::ATOM_REG, 5'd2);
    @(negedge clk);
    nChecks++;
    if (avm_read !== 1'b0 || busy !== 1'b1) begin
      nFails++; $display("[TB] FAIL mid_rd_wait read=%b busy=%b required=0/1", avm_read, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    avm_readdatavalid = 1'b1;
    avm_readdata      = 32'h12345678;
    #1;
    nChecks++;
    if (avm_read !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      nFails++; $display("[TB] FAIL mid_idle read=%b busy=%b ready=%b required=0/0/1", avm_read, busy, cmd_ready);
    end
    @(negedge clk);
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    nChecks++;
    if (read_user_data_available !== 1'b0 || read_user_buffer_output_data !== 32'h0 || write_control_done !== 1'b0) begin
      nFails++; $display("[TB] FAIL mid_late_data pulse=%b data=%h done=%b required=0/00000000/0",
                         read_user_data_available, read_user_buffer_output_data, write_control_done);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst_read();
    test_single_write();
    test_back_to_back();
    test_zero_and_clamp();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/ram_user_master.md
# ram_user_master

Responder for the FPGA memory manager's access requests: accepts a single-word or multi-word (up to one 96-byte block) read or write command, performs it as a sequence of single-word Avalon-MM master transfers to the HPS/Atom-shared SDRAM window, and returns read words as a one-cycle-valid stream or a write-completion pulse. Sits between the memory manager FSM and the SDRAM bridge.

## Interface
- ADDR_W, 28, byte address width
- DATA_W, 32, data word width
- MAX_WORDS, 24, maximum words per command (one mining block)
- LEN_W, 5, width of word-count field
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_rdwr  in  1  0 = read, 1 = write
- cmd_address  in  ADDR_W  start byte address
- cmd_words  in  LEN_W  number of words
- wr_data  in  DATA_W  current write word, held by requester until acked
- wr_data_ack  out  1  current write word consumed; present next word
- read_user_data_available  out  1  one-cycle valid for read word
- read_user_buffer_output_data  out  DATA_W  read word
- write_control_done  out  1  one-cycle pulse: write command finished
- busy  out  1  command in progress
- avm_address  out  ADDR_W  bus address, bits [1:0] always 0
- avm_read, avm_write  out  1  bus strobes
- avm_writedata  out  DATA_W  bus write data
- avm_readdata  in  DATA_W  bus read data
- avm_readdatavalid  in  1  read data valid
- avm_waitrequest  in  1  slave stall

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ.
- IDLE: cmd_ready = 1 (0 while reset high). On cmd_valid & cmd_ready, latch address (bits [1:0] cleared), direction, count; go to RD_REQ or WR_REQ.
- Count: cmd_words > MAX_WORDS saturates to MAX_WORDS. cmd_words = 0: accepted, no bus cycle; write pulses write_control_done next cycle, read produces nothing; stay IDLE.
- RD_REQ: avm_read = 1, avm_address = current address; held while avm_waitrequest = 1. Cycle with waitrequest = 0 -> RD_WAIT.
- RD_WAIT: avm_read = 0. On avm_readdatavalid: register avm_readdata to output, pulse read_user_data_available, address += 4, count -= 1; count reaches 0 -> IDLE, else -> RD_REQ. One outstanding read max.
- avm_readdatavalid outside RD_WAIT is ignored.
- WR_REQ: avm_write = 1, avm_writedata = wr_data. wr_data_ack = avm_write & ~avm_waitrequest (combinational). On ack: address += 4, count -= 1; last word -> write_control_done pulse next cycle, IDLE.
- Address arithmetic modulo 2^ADDR_W (wraps 0xFFFFFFC -> 0x0000000).
- busy = state != IDLE.

## Timing
- Reset values: state IDLE, all strobes/pulses 0, avm_address 0, read data 0, busy 0, cmd_ready 0 during reset, 1 first cycle after.
- Accept at edge N: avm_read/avm_write high from cycle N+1.
- Read data: avm_readdatavalid at edge M -> read_user_data_available high for exactly cycle M+1 with data; next avm_read no earlier than cycle M+1.
- Back-to-back commands: cmd_ready high the cycle after final read word/write ack.
- Reset mid-command: bus strobes drop at the reset edge, count discarded, no done pulse, late readdatavalid ignored.
- Minimum per-word throughput: read 2 cycles + slave latency; write 1 cycle with no waitrequest.

## Structure
- Shared package mem_pkg: state enum, MAX_WORDS, map constants ATOM_REG 28'h8000000, HDWR_REG 28'h8000004, MINE_BLOCK 28'h8000008, NONCE_BLOCK 28'h8000068, handshake value 32'hAAAA0000. Memory manager imports the same package.
- Single module; no sub-module needed.

## Test plan
- Single read ATOM_REG, slave latency 2, data 32'hAAAA0000 -> avm_address 0x8000000, one read strobe, one output pulse with 32'hAAAA0000, cmd_ready back.
- 24-word read from MINE_BLOCK with random waitrequest -> 24 pulses, addresses 0x8000008..0x8000064 step 4, data in order.
- Single write HDWR_REG, waitrequest 3 cycles -> avm_write held 4 cycles, one wr_data_ack, write_control_done one cycle after.
- cmd_words = 0 write, then 31 read -> no bus cycle + done pulse; read clamped to 24 words.
- Read at 0xFFFFFFC, 2 words -> second address 0x0000000.
- Reset asserted in RD_WAIT, readdatavalid arrives after -> no output pulse, idle, cmd_ready 1.
